// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer,
// flush with bubble insertion and two saturating perf counters (stall, flush).
module pipe_stage_skid #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready depends on state only; out_valid never depends on out_ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
    dbg_state = state_q;
  end

  // Control is zeroed whenever an entry leaves a slot so a stale entry can never
  // reappear as a live bubble; data registers are left alone.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush && (out_valid || in_valid) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed steps then random traffic, all checked
// against a queue-based model of the stage (plus a narrow-counter instance).
module tb_pipe_stage_skid;
  localparam int CW = 7;
  localparam int DW = 111;
  localparam int NW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, cnt_clr, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    dbg_state;
  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [SW-1:0] s_stall_cnt, s_flush_cnt;
  logic [1:0]    s_dbg_state;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(SW)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_last;
  int unsigned   m_stall, m_flush, m_stall_s, m_flush_s;
  int            total = 0;
  int            passed = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned sat_inc(input int unsigned v, input int w);
    int unsigned top;
    top = (32'd1 << w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last    = '0;
    m_stall   = 0;
    m_flush   = 0;
    m_stall_s = 0;
    m_flush_s = 0;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic clr);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
  endtask

  // One clock: the model consumes the inputs presented at this edge.
  task automatic step();
    bit   acc, pop, stl, fcnt;
    ent_t e;
    acc  = in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && out_ready;
    stl  = (mq.size() > 0) && !out_ready;
    fcnt = flush && ((mq.size() > 0) || in_valid);
    if (cnt_clr) begin
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      if (stl) begin
        m_stall   = sat_inc(m_stall, NW);
        m_stall_s = sat_inc(m_stall_s, SW);
      end
      if (fcnt) begin
        m_flush   = sat_inc(m_flush, NW);
        m_flush_s = sat_inc(m_flush_s, SW);
      end
    end
    e.c = in_ctrl;
    e.d = in_data;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    if (mq.size() > 0) m_last = mq[0].d;
    #1;
  endtask

  task automatic check_all(input string tag);
    bit v;
    v = (mq.size() > 0);
    chk({tag, " out_valid"}, 128'(out_valid), 128'(v));
    chk({tag, " out_ctrl"}, 128'(out_ctrl), v ? 128'(mq[0].c) : 128'(0));
    chk({tag, " out_data"}, 128'(out_data), v ? 128'(mq[0].d) : 128'(m_last));
    chk({tag, " in_ready"}, 128'(in_ready), 128'(mq.size() < 2));
    chk({tag, " occupancy"}, 128'(dbg_state), 128'(mq.size()));
    chk({tag, " stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
    chk({tag, " flush_cnt"}, 128'(flush_cnt), 128'(m_flush));
    chk({tag, " stall_cnt_w4"}, 128'(s_stall_cnt), 128'(m_stall_s));
    chk({tag, " flush_cnt_w4"}, 128'(s_flush_cnt), 128'(m_flush_s));
  endtask

  initial begin
    #5_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] da, db;

    // Reset held with upstream offering an entry
    rst = 1'b0;
    drive(1'b1, 7'h7F, rand_data(), 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    chk("reset out_ctrl", 128'(out_ctrl), 128'(0));
    rst = 1'b1;

    // Streaming at full rate
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CW'(k), DW'(k), 1'b1, 1'b0, 1'b0);
      step();
      check_all("stream");
      chk("stream out_ctrl=k", 128'(out_ctrl), 128'(k));
    end

    // Drain and clear counters, then back-pressure with A and B
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step();
    check_all("drain");
    da = rand_data();
    db = rand_data();
    drive(1'b1, 7'h11, da, 1'b0, 1'b0, 1'b0);
    step();
    check_all("bp_a");
    drive(1'b1, 7'h22, db, 1'b0, 1'b0, 1'b0);
    step();
    check_all("bp_b");
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      step();
      check_all("bp_hold");
    end
    chk("bp stall_cnt=3", 128'(stall_cnt), 128'(3));
    chk("bp in_ready=0", 128'(in_ready), 128'(0));
    chk("bp out_data=A", 128'(out_data), 128'(da));
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check_all("bp_pop_a");
    chk("bp out_ctrl=B", 128'(out_ctrl), 128'(8'h22));
    step();
    check_all("bp_pop_b");

    // Flush while full, with C offered in the same cycle
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 7'h33, rand_data(), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 7'h44, rand_data(), 1'b0, 1'b0, 1'b0);
    step();
    check_all("fl_full");
    drive(1'b1, 7'h55, rand_data(), 1'b0, 1'b1, 1'b0);
    step();
    check_all("fl_flush");
    chk("fl out_valid=0", 128'(out_valid), 128'(0));
    chk("fl flush_cnt=1", 128'(flush_cnt), 128'(1));
    drive(1'b1, 7'h66, rand_data(), 1'b1, 1'b0, 1'b0);
    step();
    check_all("fl_d");
    chk("fl out_ctrl=D", 128'(out_ctrl), 128'(8'h66));

    // Saturation of the 4-bit stall counter, then clear
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    check_all("sat");
    chk("sat stall_w4=F", 128'(s_stall_cnt), 128'(4'hF));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check_all("sat_clr");
    chk("sat_clr stall_w4=0", 128'(s_stall_cnt), 128'(0));

    // Async reset while full, then accept on the first edge after release
    drive(1'b1, 7'h0A, rand_data(), 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    model_reset();
    #2;
    check_all("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 7'h0B, rand_data(), 1'b1, 1'b0, 1'b0);
    step();
    check_all("post_reset");
    chk("post_reset out_ctrl", 128'(out_ctrl), 128'(8'h0B));

    // Random valid/ready/flush/clear traffic
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), rand_data(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 127) == 0);
      step();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
